fpu_mul_result_port: RTL and testbench
======================================

Name: fpu_mul_result_port

Overview:
- Output-side collector for the single-precision multiplier (Top_Mul); consumes the unpacked result the multiplier produces (Sz/Ez/Mz plus five exception flags).
- Packs each result into an IEEE-754 32-bit word with NaN canonicalisation.
- Buffers results in a 2-entry FIFO toward a valid/ready consumer.
- Maintains a sticky exception-flag register (fflags-style) and a saturating dropped-result counter.

Parameters:
- DEPTH, 2, FIFO entries. Only 2 is supported; pointers are 1 bit.
- DROP_W, 8, width of the dropped-result counter.

Ports:
- CLK, input, 1, clock; all state updates on the rising edge.
- RST, input, 1, asynchronous active-low reset.
- Res_valid, input, 1, multiplier result strobe, one per result.
- Sz, input, 1, result sign.
- Ez, input, 8, result biased exponent.
- Mz, input, 23, result fraction.
- Res_flags, input, 5, {invalid, overflow, underflow, inexact, zero}, bit 4 down to bit 0.
- Res_ready, output, 1, FIFO not full.
- Out_data, output, 32, packed head entry.
- Out_flags, output, 5, flags of head entry.
- Out_valid, output, 1, head entry present.
- Out_ready, input, 1, consumer accepts head.
- Flags_clr, input, 1, clear sticky flags.
- Sticky_flags, output, 5, OR of flags of all accepted results since reset or the last clear.
- Drop_cnt, output, DROP_W, count of results lost because the FIFO was full.

Behaviour:
- Reset (RST=0, asynchronous):
  - Count, pointers, Sticky_flags and Drop_cnt go to 0.
  - Out_valid=0, Res_ready=1, Out_data=0, Out_flags=0.
  - Storage contents are don't-care.
  - Assertion mid-operation discards all buffered results immediately, with no output pulse.
- Res_ready = (count != 2). It is derived from registered state only, with no combinational path from Out_ready.
- Push: Res_valid && Res_ready at an edge writes the packed entry at the write pointer and increments count.
- Pop: Out_valid && Out_ready at an edge advances the read pointer and decrements count.
- Simultaneous push and pop with count=1: count stays 1 and both pointers advance.
- When full, a push is not accepted even if a pop occurs in the same cycle. The result is dropped and Drop_cnt increments.
- Drop_cnt saturates at all-ones. It clears only on reset.
- Pop with count=0 is impossible because Out_valid=0; Out_ready is ignored.
- Out_valid = (count != 0). Out_data and Out_flags come from registered storage at the read pointer.
- Latency: a result pushed at edge N is visible on Out_data with Out_valid=1 after edge N, when the FIFO was empty.
- Packing rules:
  - If Res_flags[4] (invalid) is set, store 0x7FC00000 (canonical qNaN, sign forced 0), regardless of Sz/Ez/Mz.
  - Else if Res_flags[0] (zero) is set, store {Sz, 31'b0}.
  - Else store {Sz, Ez, Mz}.
- Out_flags is the raw Res_flags of the entry, unmodified.
- Sticky flags:
  - On an accepted push: Sticky_flags <= (Flags_clr ? 0 : Sticky_flags) | Res_flags. A clear and a push in the same cycle therefore leave only the new flags.
  - Flags_clr alone clears to 0.
  - Dropped results do not update Sticky_flags.
- Ordering: strict FIFO. Wrap-around of the 1-bit pointers is natural modulo 2.

Test Plan:
1. Reset check: assert RST low mid-run with count=2 -> Out_valid=0, Res_ready=1, Sticky_flags=0, Drop_cnt=0 immediately, without waiting for CLK.
2. Normal packing: push Sz=0, Ez=0x8E, Mz=0x7FFFFF, flags=0b00010, Out_ready=1 -> next cycle Out_data=0x477FFFFF, Out_flags=0b00010, Sticky_flags=0b00010.
3. Canonicalisation:
   - Push Sz=1, Ez=0xFF, Mz=0x000123, flags=0b10000 -> Out_data=0x7FC00000.
   - Push Sz=1, Ez=0x00, Mz=0x000004, flags=0b00101 -> Out_data=0x80000000.
4. Backpressure and drop: Out_ready=0; push A, B, C on consecutive cycles -> Res_ready=0 after B, C dropped, Drop_cnt=1. Then Out_ready=1 -> A then B delivered in order, Out_valid falls after B.
5. Simultaneous push/pop at count=1: hold Out_ready=1 and stream 6 back-to-back results -> each output exactly one cycle after its push, count stays 1, no drops, pointer wrap-around exercised.
6. Sticky clear race: Sticky_flags=0b01000; assert Flags_clr together with a push of flags=0b00010 -> Sticky_flags=0b00010. Flags_clr alone next cycle -> 0b00000.

Source files
------------

// File: rtl/fpu_mul_result_port_if.sv
// fpu_mul_result_port_if: result bus between the multiplier collector and its downstream consumer
interface fpu_mul_result_port_if #(
    parameter int DROP_W = 8
);
    logic              Res_valid;
    logic              Sz;
    logic [7:0]        Ez;
    logic [22:0]       Mz;
    logic [4:0]        Res_flags;
    logic              Res_ready;
    logic [31:0]       Out_data;
    logic [4:0]        Out_flags;
    logic              Out_valid;
    logic              Out_ready;
    logic              Flags_clr;
    logic [4:0]        Sticky_flags;
    logic [DROP_W-1:0] Drop_cnt;

    modport master (
        output Res_valid, Sz, Ez, Mz, Res_flags, Out_ready, Flags_clr,
        input  Res_ready, Out_data, Out_flags, Out_valid, Sticky_flags, Drop_cnt
    );

    modport slave (
        input  Res_valid, Sz, Ez, Mz, Res_flags, Out_ready, Flags_clr,
        output Res_ready, Out_data, Out_flags, Out_valid, Sticky_flags, Drop_cnt
    );
endinterface

// File: rtl/fpu_mul_result_port.sv
// fpu_mul_result_port: packs multiplier results, buffers them in a 2-entry FIFO, tracks sticky flags and drops
module fpu_mul_result_port #(
    parameter int DEPTH  = 2,
    parameter int DROP_W = 8
) (
    input logic                 CLK,
    input logic                 RST,
    fpu_mul_result_port_if.slave bus
);
    logic [31:0]       data_q [2];
    logic [4:0]        flags_q [2];
    logic              wp_q, wp_d;
    logic              rp_q, rp_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [4:0]        sticky_q, sticky_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              full, valid, push, pop, drop;
    logic [31:0]       packed_word;

    assign full  = cnt_q == 2'(DEPTH);
    assign valid = cnt_q != 2'd0;
    assign push  = bus.Res_valid && !full;
    assign pop   = valid && bus.Out_ready;
    assign drop  = bus.Res_valid && full;

    assign packed_word = bus.Res_flags[4] ? 32'h7FC0_0000 :
                         bus.Res_flags[0] ? {bus.Sz, 31'b0} :
                                            {bus.Sz, bus.Ez, bus.Mz};

    assign bus.Res_ready    = !full;
    assign bus.Out_valid    = valid;
    assign bus.Out_data     = valid ? data_q[rp_q] : 32'b0;
    assign bus.Out_flags    = valid ? flags_q[rp_q] : 5'b0;
    assign bus.Sticky_flags = sticky_q;
    assign bus.Drop_cnt     = drop_q;

    // next-state for pointers, occupancy, sticky flags and the saturating drop counter
    always_comb begin
        wp_d     = push ? ~wp_q : wp_q;
        rp_d     = pop ? ~rp_q : rp_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        sticky_d = push ? ((bus.Flags_clr ? 5'b0 : sticky_q) | bus.Res_flags) :
                   bus.Flags_clr ? 5'b0 : sticky_q;
        drop_d   = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end

    // control state; reset empties the FIFO at once
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
            sticky_q <= 5'b0;
            drop_q   <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            drop_q   <= drop_d;
        end
    end

    // storage needs no reset: entries are only read while counted as valid
    always_ff @(posedge CLK) begin
        if (push) begin
            data_q[wp_q]  <= packed_word;
            flags_q[wp_q] <= bus.Res_flags;
        end
    end
endmodule

// File: tb/tb_fpu_mul_result_port.sv
// tb_fpu_mul_result_port: vector table plus scoreboard bench for the multiplier result port
module tb_fpu_mul_result_port;
    typedef struct {
        logic        sz;
        logic [7:0]  ez;
        logic [22:0] mz;
        logic [4:0]  fl;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  f;
    } ent_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    fpu_mul_result_port_if #(.DROP_W(8)) bus();

    fpu_mul_result_port #(.DEPTH(2), .DROP_W(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    ent_t        sb[$];
    logic [4:0]  m_sticky = 5'b0;
    logic [7:0]  m_drop = 8'b0;
    logic [31:0] exp_word = 32'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_pack(input logic sz, input logic [7:0] ez,
                                             input logic [22:0] mz, input logic [4:0] fl);
        if (fl[4]) return 32'h7FC0_0000;
        if (fl[0]) return {sz, 31'b0};
        return {sz, ez, mz};
    endfunction

    // reference model: compares the DUT with the queue and then advances across the coming edge
    always @(negedge CLK) begin
        logic acc;
        if (!RST) begin
            sb.delete();
            m_sticky = 5'b0;
            m_drop   = 8'b0;
        end else begin
            chk("res_ready", 32'(bus.Res_ready), 32'(sb.size() != 2));
            chk("out_valid", 32'(bus.Out_valid), 32'(sb.size() != 0));
            chk("sticky", 32'(bus.Sticky_flags), 32'(m_sticky));
            chk("drop_cnt", 32'(bus.Drop_cnt), 32'(m_drop));
            if (sb.size() != 0) begin
                chk("out_data", bus.Out_data, sb[0].d);
                chk("out_flags", 32'(bus.Out_flags), 32'(sb[0].f));
            end
            acc = bus.Res_valid && sb.size() != 2;
            if (bus.Res_valid && !acc && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            m_sticky = acc ? ((bus.Flags_clr ? 5'b0 : m_sticky) | bus.Res_flags) :
                       bus.Flags_clr ? 5'b0 : m_sticky;
            if (sb.size() != 0 && bus.Out_ready) void'(sb.pop_front());
            if (acc) sb.push_back('{exp_word, bus.Res_flags});
        end
    end

    task automatic push(input logic sz, input logic [7:0] ez, input logic [22:0] mz,
                        input logic [4:0] fl, input logic [31:0] ew, input logic clr);
        @(posedge CLK);
        #1;
        bus.Res_valid = 1'b1;
        bus.Sz        = sz;
        bus.Ez        = ez;
        bus.Mz        = mz;
        bus.Res_flags = fl;
        bus.Flags_clr = clr;
        exp_word      = ew;
    endtask

    task automatic idle(input logic clr);
        @(posedge CLK);
        #1;
        bus.Res_valid = 1'b0;
        bus.Flags_clr = clr;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && bus.Out_valid; i++) @(posedge CLK);
        @(negedge CLK);
        chk("drain_empty", 32'(bus.Out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[9];
        tbl[0] = '{1'b0, 8'h8E, 23'h7FFFFF, 5'b00010, 32'h477F_FFFF};
        tbl[1] = '{1'b1, 8'hFF, 23'h000123, 5'b10000, 32'h7FC0_0000};
        tbl[2] = '{1'b1, 8'h00, 23'h000004, 5'b00101, 32'h8000_0000};
        tbl[3] = '{1'b0, 8'h7F, 23'h000000, 5'b00000, 32'h3F80_0000};
        tbl[4] = '{1'b1, 8'h80, 23'h400000, 5'b00000, 32'hC040_0000};
        tbl[5] = '{1'b0, 8'h00, 23'h000000, 5'b00001, 32'h0000_0000};
        tbl[6] = '{1'b0, 8'hFF, 23'h000000, 5'b01010, 32'h7F80_0000};
        tbl[7] = '{1'b0, 8'h12, 23'h345678, 5'b10001, 32'h7FC0_0000};
        tbl[8] = '{1'b1, 8'h01, 23'h000001, 5'b00100, 32'h8080_0001};

        bus.Res_valid = 1'b0;
        bus.Sz        = 1'b0;
        bus.Ez        = 8'h0;
        bus.Mz        = 23'h0;
        bus.Res_flags = 5'b0;
        bus.Flags_clr = 1'b0;
        bus.Out_ready = 1'b1;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", 32'(bus.Out_valid), 32'd0);
        chk("rst_res_ready", 32'(bus.Res_ready), 32'd1);
        chk("rst_out_data", bus.Out_data, 32'd0);
        chk("rst_out_flags", 32'(bus.Out_flags), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b1;

        // first entry alone so its packing, flags and sticky update are seen in isolation
        push(tbl[0].sz, tbl[0].ez, tbl[0].mz, tbl[0].fl, tbl[0].exp_word, 1'b0);
        idle(1'b0);
        @(negedge CLK);
        chk("t2_data", bus.Out_data, 32'h477F_FFFF);
        chk("t2_sticky", 32'(bus.Sticky_flags), 32'h02);
        drain();

        foreach (tbl[i]) push(tbl[i].sz, tbl[i].ez, tbl[i].mz, tbl[i].fl, tbl[i].exp_word, 1'b0);
        idle(1'b0);
        drain();

        // backpressure: A and B fill the FIFO, C is dropped
        bus.Out_ready = 1'b0;
        push(1'b0, 8'h81, 23'h00000A, 5'b00000, 32'h4080_000A, 1'b0);
        push(1'b0, 8'h82, 23'h00000B, 5'b00000, 32'h4100_000B, 1'b0);
        push(1'b0, 8'h83, 23'h00000C, 5'b00000, 32'h4180_000C, 1'b0);
        @(negedge CLK);
        chk("t4_full", 32'(bus.Res_ready), 32'd0);
        idle(1'b0);
        @(negedge CLK);
        chk("t4_drop", 32'(bus.Drop_cnt), 32'd1);
        chk("t4_head_a", bus.Out_data, 32'h4080_000A);
        bus.Out_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("t4_head_b", bus.Out_data, 32'h4100_000B);
        drain();

        // streaming at count one: pointers wrap several times
        for (int i = 0; i < 6; i++) begin
            logic        sz;
            logic [7:0]  ez;
            logic [22:0] mz;
            logic [4:0]  fl;
            sz = 1'($urandom);
            ez = 8'($urandom_range(1, 254));
            mz = 23'($urandom);
            fl = (i == 3) ? 5'b10000 : 5'($urandom) & 5'b01110;
            push(sz, ez, mz, fl, ref_pack(sz, ez, mz, fl), 1'b0);
        end
        idle(1'b0);
        @(negedge CLK);
        chk("t5_no_new_drops", 32'(bus.Drop_cnt), 32'd1);
        drain();

        // sticky clear racing a push
        idle(1'b1);
        push(1'b0, 8'h90, 23'h0, 5'b01000, 32'h4800_0000, 1'b0);
        idle(1'b0);
        @(negedge CLK);
        chk("t6_sticky_set", 32'(bus.Sticky_flags), 32'h08);
        push(1'b0, 8'h91, 23'h1, 5'b00010, 32'h4880_0001, 1'b1);
        idle(1'b0);
        @(negedge CLK);
        chk("t6_clr_push", 32'(bus.Sticky_flags), 32'h02);
        idle(1'b1);
        idle(1'b0);
        @(negedge CLK);
        chk("t6_clr_only", 32'(bus.Sticky_flags), 32'h00);
        drain();

        // drop counter saturation
        bus.Out_ready = 1'b0;
        push(1'b1, 8'h70, 23'h55, 5'b00011, 32'h8000_0000, 1'b0);
        repeat (261) @(posedge CLK);
        #1 bus.Res_valid = 1'b0;
        @(negedge CLK);
        chk("sat_drop", 32'(bus.Drop_cnt), 32'hFF);
        chk("sat_sticky", 32'(bus.Sticky_flags), 32'h03);

        // asynchronous reset with a full FIFO, away from any clock edge
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        chk("t1_out_valid", 32'(bus.Out_valid), 32'd0);
        chk("t1_res_ready", 32'(bus.Res_ready), 32'd1);
        chk("t1_sticky", 32'(bus.Sticky_flags), 32'd0);
        chk("t1_drop", 32'(bus.Drop_cnt), 32'd0);
        chk("t1_out_data", bus.Out_data, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b1;
        bus.Out_ready = 1'b1;
        push(tbl[4].sz, tbl[4].ez, tbl[4].mz, tbl[4].fl, tbl[4].exp_word, 1'b0);
        idle(1'b0);
        @(negedge CLK);
        chk("post_rst_data", bus.Out_data, 32'hC040_0000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
